auth_request_arbiter: RTL
=========================

# auth_request_arbiter

Arbitrates pending authentication requests from the PD driver and the DEBUG driver onto the single shared authentication engine of the USB Type-C authentication controller. Each driver posts up to four 2-bit request codes; the arbiter picks one, round-robin between sources, issues it to the engine with a valid/ready handshake, and waits for completion. It then pulses the owning driver's erase strobe so that slot is cleared.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: engine completion watchdog limit in clk cycles; only used with the watchdog compiled in.
- CNT_W, 11: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pending_auth_request_PD  in  8  four 2-bit slots; slot i is bits [2i+1:2i]. Codes: 00 empty, 01 GET_DIGESTS, 10 GET_CERTIFICATE, 11 CHALLENGE.
- pending_auth_request_DEBUG  in  8  same encoding for the DEBUG driver.
- auth_req_ready  in  1  engine accepts a request.
- auth_done  in  1  single-cycle engine completion pulse.
- auth_req_valid  out  1  request offered to the engine.
- auth_req_type  out  2  code of the granted slot.
- auth_req_src  out  1  0 = PD, 1 = DEBUG.
- auth_req_slot  out  2  index of the granted slot.
- pending_auth_request_PD_erase  out  1  one-cycle clear strobe to the PD driver.
- pending_auth_request_DEBUG_erase  out  1  one-cycle clear strobe to the DEBUG driver.
- erase_slot  out  2  slot index qualified by either erase strobe.
- arb_busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, ERASE.
- IDLE:
  - A source is pending when any of its slots is nonzero.
  - Within a source, the lowest-index nonzero slot wins.
  - If both sources are pending, the source not granted last (last_src) wins. If only one is pending, it wins regardless of last_src.
  - On a win: latch src, slot and type; update last_src; go to ISSUE.
- ISSUE: auth_req_valid high. type, src and slot stay stable until auth_req_valid && auth_req_ready, then go to WAIT_DONE.
- WAIT_DONE: on auth_done, go to ERASE. auth_done in any other state is ignored.
- ERASE: assert the latched source's erase strobe for exactly one cycle with erase_slot set to the latched slot, then go to IDLE.
- The arbiter never samples the pending vectors in ERASE. The driver clears the slot on that edge, so the next IDLE sees the updated vector.
- Pending vector changes after the latch in IDLE do not affect the in-flight request.
- Reset (any time, including mid-operation):
  - State goes to IDLE; last_src = DEBUG, so PD wins the first tie.
  - All outputs are 0, including timeout_err.
  - No erase is issued; the interrupted request stays pending in its driver and is re-arbitrated.

## Timing
- All outputs are registered.
- Pending visible at edge t in IDLE: auth_req_valid is high from t+1.
- With auth_req_ready already high, the handshake completes at edge t+1 and the state is WAIT_DONE from t+1.
- auth_done sampled at edge d: the erase strobe is high for cycle d+1 only; IDLE from d+2.
- Minimum spacing between consecutive auth_req_valid rises is 4 cycles.
- auth_req_valid never drops without a completed handshake, except on reset.

## Configuration
- AUTH_ARB_WATCHDOG_EN defined:
  - A counter clears on entry to WAIT_DONE and increments each cycle in that state.
  - When it reaches TIMEOUT_CYCLES without auth_done: set timeout_err (cleared only by reset) and go to ERASE, which drops the stuck request.
  - If auth_done and the timeout occur in the same cycle, auth_done wins and timeout_err is not set.
- Not defined: no counter is built, timeout_err is tied to 0, and WAIT_DONE waits indefinitely.

## Structure
- Shared package/header `auth_pkg`:
  - request code constants (REQ_NONE, REQ_DIGESTS, REQ_CERT, REQ_CHALLENGE)
  - state encoding
  - SRC_PD / SRC_DEBUG constants
- One sub-module, `auth_slot_pick`: combinational; takes an 8-bit vector and returns a nonzero flag, the lowest nonzero slot index and its code. It is instantiated once per source.

## Test plan
- PD = 8'b00_10_00_11, DEBUG = 0, ready tied high → type=11, src=0, slot=0; after auth_done, PD erase with erase_slot=0; next grant is type=10, slot=2.
- PD and DEBUG both 8'b00_00_00_01, continuous service → grants alternate PD, DEBUG, PD… starting with PD after reset.
- auth_req_ready held low for 5 cycles → auth_req_valid, type, src and slot stable all 5 cycles; transfer on the cycle ready rises.
- auth_done pulsed while in ISSUE → ignored, state stays ISSUE/WAIT_DONE; only a WAIT_DONE pulse triggers erase.
- Reset asserted in WAIT_DONE → all outputs 0 and no erase strobe; after release the same slot is re-granted.
- Watchdog build, TIMEOUT_CYCLES=8, no auth_done → erase strobe 8 cycles after WAIT_DONE entry and timeout_err=1 held; without the macro the arbiter stays in WAIT_DONE.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared types and constants for the authentication request arbiter.
package auth_pkg;

  localparam int NUM_SRC   = 2;
  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] REQ_NONE      = 2'b00;
  localparam logic [1:0] REQ_DIGESTS   = 2'b01;
  localparam logic [1:0] REQ_CERT      = 2'b10;
  localparam logic [1:0] REQ_CHALLENGE = 2'b11;

  localparam logic SRC_PD    = 1'b0;
  localparam logic SRC_DEBUG = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ERASE} arb_state_e;

  typedef struct packed {
    logic       src;
    logic [1:0] slot;
    logic [1:0] code;
  } auth_req_t;

endpackage

// File: rtl/auth_slot_pick.sv
// Lowest-index nonzero slot finder for one driver's 4 x 2-bit request vector.
module auth_slot_pick
  import auth_pkg::*;
(
  input  logic [2*NUM_SLOTS-1:0] pending,
  output logic                   any,
  output logic [1:0]             slot,
  output logic [1:0]             code
);

  // Scan high to low so the last hit written is the lowest index.
  always_comb begin
    any  = 1'b0;
    slot = 2'd0;
    code = REQ_NONE;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending[2*i +: 2] != REQ_NONE) begin
        any  = 1'b1;
        slot = 2'(i);
        code = pending[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/auth_request_arbiter.sv
// Round-robin PD/DEBUG arbiter onto the shared authentication engine.
// Optional completion watchdog: define AUTH_ARB_WATCHDOG_EN.
module auth_request_arbiter
  import auth_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pending_auth_request_PD,
  input  logic [7:0] pending_auth_request_DEBUG,
  input  logic       auth_req_ready,
  input  logic       auth_done,
  output logic       auth_req_valid,
  output logic [1:0] auth_req_type,
  output logic       auth_req_src,
  output logic [1:0] auth_req_slot,
  output logic       pending_auth_request_PD_erase,
  output logic       pending_auth_request_DEBUG_erase,
  output logic [1:0] erase_slot,
  output logic       arb_busy,
  output logic       timeout_err
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [NUM_SRC-1:0][2*NUM_SLOTS-1:0] src_vec;
  logic [NUM_SRC-1:0]                  src_any;
  logic [NUM_SRC-1:0][1:0]             src_slot;
  logic [NUM_SRC-1:0][1:0]             src_code;

  assign src_vec = {pending_auth_request_DEBUG, pending_auth_request_PD};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_pick
    auth_slot_pick u_pick (
      .pending (src_vec[g]),
      .any     (src_any[g]),
      .slot    (src_slot[g]),
      .code    (src_code[g])
    );
  end

  arb_state_e state, state_n;
  auth_req_t  req, req_n;
  logic       last_src, last_src_n, win;
  logic       valid_n, pd_erase_n, dbg_erase_n, busy_n, timeout_n;
  logic [1:0] erase_slot_n;
  logic       hit_timeout;

`ifdef AUTH_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  // Held at zero outside WAIT_DONE, so every entry starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wd_cnt <= '0;
    else if (state != WAIT_DONE) wd_cnt <= '0;
    else                         wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign hit_timeout = (state == WAIT_DONE) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign hit_timeout = 1'b0;
`endif

  always_comb begin
    state_n      = state;
    req_n        = req;
    last_src_n   = last_src;
    win          = 1'b0;
    valid_n      = 1'b0;
    pd_erase_n   = 1'b0;
    dbg_erase_n  = 1'b0;
    erase_slot_n = 2'd0;
    timeout_n    = timeout_err;
    unique case (state)
      IDLE: if (|src_any) begin
        // A lone requester wins outright; on a tie the other side of last_src wins.
        win        = (&src_any) ? ~last_src : src_any[SRC_DEBUG];
        req_n.src  = win;
        req_n.slot = src_slot[win];
        req_n.code = src_code[win];
        last_src_n = win;
        valid_n    = 1'b1;
        state_n    = ISSUE;
      end
      ISSUE: begin
        if (auth_req_valid && auth_req_ready) state_n = WAIT_DONE;
        else                                  valid_n = 1'b1;
      end
      WAIT_DONE: if (auth_done || hit_timeout) begin
        timeout_n    = timeout_err | ~auth_done;
        pd_erase_n   = (req.src == SRC_PD);
        dbg_erase_n  = (req.src == SRC_DEBUG);
        erase_slot_n = req.slot;
        state_n      = ERASE;
      end
      ERASE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                            <= IDLE;
      req                              <= '0;
      last_src                         <= SRC_DEBUG;
      auth_req_valid                   <= 1'b0;
      pending_auth_request_PD_erase    <= 1'b0;
      pending_auth_request_DEBUG_erase <= 1'b0;
      erase_slot                       <= 2'd0;
      arb_busy                         <= 1'b0;
      timeout_err                      <= 1'b0;
    end else begin
      state                            <= state_n;
      req                              <= req_n;
      last_src                         <= last_src_n;
      auth_req_valid                   <= valid_n;
      pending_auth_request_PD_erase    <= pd_erase_n;
      pending_auth_request_DEBUG_erase <= dbg_erase_n;
      erase_slot                       <= erase_slot_n;
      arb_busy                         <= busy_n;
      timeout_err                      <= timeout_n;
    end
  end

  assign auth_req_type = req.code;
  assign auth_req_src  = req.src;
  assign auth_req_slot = req.slot;

endmodule
